// File: rtl/cp0.sv
// MIPS-style coprocessor 0: SR / Cause / EPC registers with interrupt and
// exception request generation for a five-stage pipeline (M-stage commit).
module cp0 (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  typedef enum logic [4:0] {
    REG_SR    = 5'd12,
    REG_CAUSE = 5'd13,
    REG_EPC   = 5'd14
  } cp0_reg_e;

  // Only the architected fields are stored; unused bits are constant zero.
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_aligned;
  logic [31:0] epc_trap;
  logic [31:0] sr_value;
  logic [31:0] cause_value;

  // The low PC bits are discarded when the trap address is word-aligned.
  logic unused_pc_bits;
  assign unused_pc_bits = ^PC[1:0];

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;

  // Gated by reset so a stale ExcCodeIn cannot raise a request while held.
  assign Req = (int_req | exc_req) & ~reset;

  assign pc_aligned = {PC[31:2], 2'b00};
  assign epc_trap   = BDIn ? (pc_aligned - 32'd4) : pc_aligned;

  assign sr_value    = {16'h0, im, 8'h0, exl, ie};
  assign cause_value = {bd, 15'h0, ip, 3'h0, exc_code, 2'b00};

  // NOTE: all state uses non-blocking assignments so every read of a CP0
  // register in this block sees the value from before the current edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        epc      <= epc_trap;
      end else begin
        if (WE && (A2 == REG_SR)) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (WE && (A2 == REG_EPC)) begin
          epc <= DIn;
        end
        // Last assignment wins: eret clears EXL even over a same-edge SR write.
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    DOut = 32'h0;
    unique case (A1)
      REG_SR:    DOut = sr_value;
      REG_CAUSE: DOut = cause_value;
      REG_EPC:   DOut = epc;
      default:   DOut = 32'h0;
    endcase
  end

  assign EPCOut = epc;

endmodule

// File: tb/tb_cp0.sv
// Directed self-checking bench for cp0: reset, interrupt entry, exception
// entry in a delay slot, priority rules, eret and mid-handler reset.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int checks   = 0;
  int failures = 0;

  cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .WE        (WE),
    .PC        (PC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .Req       (Req),
    .EPCOut    (EPCOut),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic read_reg(input logic [4:0] num, input string tag,
                          input logic [31:0] expected);
    A1 = num;
    #1;
    check(tag, DOut, expected);
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; WE = 1'b0; PC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = 6'h3F; EXLClr = 1'b0;
    #2;
    // Reset state
    read_reg(5'd12, "rst_sr", 32'h0);
    read_reg(5'd13, "rst_cause", 32'h0);
    read_reg(5'd14, "rst_epc", 32'h0);
    check("rst_epcout", {31'h0, 1'b0} | EPCOut, 32'h0);
    check("rst_req_hwint", {31'h0, Req}, 32'h0);
    ExcCodeIn = 5'd4;
    #1;
    check("rst_req_exc", {31'h0, Req}, 32'h0);
    ExcCodeIn = 5'd0;
    edge_settle();
    reset = 1'b0;

    // Enable interrupts through mtc0 SR; no write-through on DOut
    HWInt = 6'b000100; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    read_reg(5'd12, "sr_no_bypass", 32'h0);
    check("req_before_ie", {31'h0, Req}, 32'h0);
    edge_settle();
    WE = 1'b0; PC = 32'h0000_2000;
    read_reg(5'd12, "sr_written", 32'h0000_FC01);
    check("int_req_same_cycle", {31'h0, Req}, 32'h1);
    edge_settle();
    check("int_no_nest", {31'h0, Req}, 32'h0);
    read_reg(5'd13, "int_cause", 32'h0000_1000);
    read_reg(5'd12, "int_sr_exl", 32'h0000_FC03);
    read_reg(5'd14, "int_epc", 32'h0000_2000);

    // Clear SR, then AdEL in a delay slot with IE=0
    WE = 1'b1; A2 = 5'd12; DIn = 32'h0; HWInt = 6'h0;
    edge_settle();
    WE = 1'b0;
    read_reg(5'd12, "sr_cleared", 32'h0);
    ExcCodeIn = 5'd4; PC = 32'h0000_3008; BDIn = 1'b1;
    #1;
    check("exc_req", {31'h0, Req}, 32'h1);
    edge_settle();
    check("exc_no_nest", {31'h0, Req}, 32'h0);
    read_reg(5'd14, "exc_epc_bd", 32'h0000_3004);
    read_reg(5'd13, "exc_cause", 32'h8000_0010);
    read_reg(5'd12, "exc_sr", 32'h0000_0002);
    check("exc_epcout", EPCOut, 32'h0000_3004);
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    WE = 1'b1; A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    edge_settle();
    WE = 1'b0;
    read_reg(5'd13, "cause_readonly", 32'h8000_0010);
    read_reg(5'd0, "dout_unmapped0", 32'h0);
    read_reg(5'd15, "dout_unmapped15", 32'h0);

    // eret with SR write, then interrupt beats exception and blocks mtc0 EPC
    EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0801;
    edge_settle();
    EXLClr = 1'b0; WE = 1'b0;
    read_reg(5'd12, "sr_eret", 32'h0000_0801);
    HWInt = 6'b000010; ExcCodeIn = 5'd10; WE = 1'b1; A2 = 5'd14;
    DIn = 32'h0000_1234; PC = 32'h0000_4004;
    #1;
    check("prio_req", {31'h0, Req}, 32'h1);
    edge_settle();
    WE = 1'b0; ExcCodeIn = 5'd0;
    read_reg(5'd14, "prio_epc_not_din", 32'h0000_4004);
    read_reg(5'd13, "prio_cause_int", 32'h0000_0800);
    read_reg(5'd12, "prio_sr", 32'h0000_0803);

    // EXLClr overrides DIn[1]; pending interrupt fires next cycle
    HWInt = 6'b000011; EXLClr = 1'b1; WE = 1'b1; A2 = 5'd12;
    DIn = 32'h0000_0403;
    #1;
    check("eret_req_blocked", {31'h0, Req}, 32'h0);
    edge_settle();
    WE = 1'b0;
    read_reg(5'd12, "eret_sr_override", 32'h0000_0401);
    check("pending_int_req", {31'h0, Req}, 32'h1);
    PC = 32'h0000_5000;
    edge_settle();
    EXLClr = 1'b0;
    read_reg(5'd12, "exlclr_ignored", 32'h0000_0403);
    read_reg(5'd13, "pending_cause", 32'h0000_0C00);
    read_reg(5'd14, "pending_epc", 32'h0000_5000);

    // Reset mid-handler, between edges
    #1;
    reset = 1'b1;
    read_reg(5'd12, "midrst_sr", 32'h0);
    read_reg(5'd13, "midrst_cause", 32'h0);
    read_reg(5'd14, "midrst_epc", 32'h0);
    check("midrst_epcout", EPCOut, 32'h0);
    check("midrst_req", {31'h0, Req}, 32'h0);
    reset = 1'b0; HWInt = 6'h0;
    edge_settle();
    read_reg(5'd13, "post_rst_cause", 32'h0);
    check("post_rst_req", {31'h0, Req}, 32'h0);
    ExcCodeIn = 5'd12; PC = 32'h0000_6002; BDIn = 1'b0;
    #1;
    check("fresh_exc_req", {31'h0, Req}, 32'h1);
    edge_settle();
    ExcCodeIn = 5'd0;
    read_reg(5'd14, "fresh_epc_aligned", 32'h0000_6000);
    read_reg(5'd13, "fresh_cause", 32'h0000_0030);
    read_reg(5'd12, "fresh_sr", 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 A1  input  5  read register number (12 SR, 13 Cause, 14 EPC).
REQ-004 A2  input  5  write register number.
REQ-005 DIn  input  32  write data (mtc0).
REQ-006 WE  input  1  write enable (mtc0 in M stage).
REQ-007 PC  input  32  PC of instruction currently in M stage.
REQ-008 BDIn  input  1  M-stage instruction sits in a branch delay slot.
REQ-009 ExcCodeIn  input  5  exception code carried to M stage; 0 = none.
REQ-010 HWInt  input  6  external interrupt lines (level).
REQ-011 EXLClr  input  1  eret in M stage.
REQ-012 Req  output  1  combinational exception/interrupt request to the fetch unit and pipeline flush.
REQ-013 EPCOut  output  32  current EPC register value, eret target.
REQ-014 DOut  output  32  combinational read data (mfc0).

Function
REQ-015 SR fields: IM = SR[15:10], EXL = SR[1], IE = SR[0]; all other SR bits read 0 and ignore writes.
REQ-016 Cause fields: BD = Cause[31], IP = Cause[15:10], ExcCode = Cause[6:2]; all other bits read 0.
REQ-017 IntReq = |(HWInt & IM) & IE & !EXL.
REQ-018 ExcReq = (ExcCodeIn != 0) & !EXL.
REQ-019 Req = IntReq | ExcReq, same cycle, no register delay.
REQ-020 On clock edge with Req=1: EXL <= 1; BD <= BDIn; ExcCode <= IntReq ? 0 : ExcCodeIn (interrupt wins over simultaneous exception); EPC <= BDIn ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}.
REQ-021 IP <= HWInt on every edge, regardless of Req, EXL, WE.
REQ-022 On edge with Req=0 and WE=1: A2=12 writes SR from DIn masked fields; A2=14 writes EPC <= DIn; A2=13 and any other number are ignored (Cause is read-only to software).
REQ-023 WE is ignored on any edge where Req=1 (the faulting instruction must not commit).
REQ-024 On edge with EXLClr=1 and Req=0: EXL <= 0; if WE targets SR the same edge, the EXL clear overrides DIn[1].
REQ-025 EXLClr is ignored when Req=1; Req handling takes priority.
REQ-026 With EXL=1, Req stays 0 for every interrupt and exception (no nesting).
REQ-027 DOut = SR, Cause or EPC for A1 = 12/13/14, otherwise 32'h0; reflects register contents before the current edge (no write-through bypass).
REQ-028 EPCOut always equals the EPC register.
REQ-029 Resulting fetch behaviour: fetch unit redirects to 32'h4180 on the edge where Req=1; the fetch-address AdEL code (4) reaches ExcCodeIn through the pipeline.

Reset
REQ-030 reset=1 asynchronously forces SR, Cause, EPC to 32'h0; Req, DOut (for any A1) and EPCOut read 0 while reset is held.
REQ-031 Reset asserted mid-handler (EXL=1) clears EXL; first edge after release behaves as fresh state.

Verification
REQ-032 Reset, then A1=12/13/14 -> DOut=0; EPCOut=0; Req=0 with HWInt=6'h3F.
REQ-033 mtc0 SR DIn=32'h0000_FC01, HWInt=6'b000100 -> Req=1 same cycle; after edge Cause=32'h0000_1000 (IP=4, ExcCode=0), EXL=1, EPC=PC; then Req=0 though HWInt held.
REQ-034 ExcCodeIn=4 (AdEL), PC=32'h0000_3008, BDIn=1, IE=0 -> Req=1; after edge EPC=32'h3004, Cause=32'h8000_0010, SR[1]=1.
REQ-035 Same edge: HWInt enabled interrupt and ExcCodeIn=10 -> Cause.ExcCode=0; WE=1 to EPC with DIn=32'h1234 the same edge -> EPC holds trapped PC, not 32'h1234.
REQ-036 EXL=1, EXLClr=1 with WE=1 A2=12 DIn=32'h0000_0403 -> SR=32'h0000_0401; pending enabled interrupt raises Req next cycle.
REQ-037 Assert reset between clock edges while EXL=1 -> SR/Cause/EPC read 0 before next edge.
